// File: rtl/fixed_to_float.sv
`default_nettype none
// ============================================================================
// Module   : fixed_to_float
// Purpose  : Q2.24 signed fixed-point to IEEE-754 single precision converter,
//            valid/ready pipeline (S1 sign/magnitude, S2 leading-one,
//            S3 normalise, output stage rounds and packs). 3-cycle latency.
// Options  : FIXED_TO_FLOAT_ROUND_EN - round-to-nearest-even when defined,
//            truncation toward zero otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] fixedpoint_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [7:0] c_exp_bias = 8'd103;
    localparam logic [4:0] c_top_bit  = 5'd25;

    // Global pipeline enable: every stage moves together or not at all.
    logic        w_advance;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic [25:0] s1_mag_q,   s1_mag_d;

    logic        s2_valid_q, s2_valid_d;
    logic        s2_sign_q,  s2_sign_d;
    logic [25:0] s2_mag_q,   s2_mag_d;
    logic [4:0]  s2_pos_q,   s2_pos_d;

    logic        s3_valid_q, s3_valid_d;
    logic        s3_sign_q,  s3_sign_d;
    logic        s3_zero_q,  s3_zero_d;
    logic [7:0]  s3_exp_q,   s3_exp_d;
    logic [22:0] s3_frac_q,  s3_frac_d;
`ifdef FIXED_TO_FLOAT_ROUND_EN
    logic [1:0]  s3_grd_q,   s3_grd_d;
`endif

    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q,    result_d;

    logic [25:0] w_mag;
    logic [4:0]  w_pos;
    logic [25:0] w_norm;
    logic [7:0]  w_exp_rnd;
    logic [22:0] w_frac_rnd;
    logic [31:0] w_packed;

    assign w_advance = ~(out_valid_q & ~out_ready);
    assign in_ready  = w_advance;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Magnitude of -2.0 is 2^25, which still fits the unsigned 26-bit field.
    assign w_mag = fixedpoint_in[25] ? (~fixedpoint_in + 26'd1) : fixedpoint_in;

    always_comb begin
        w_pos = '0;
        for (int i = 0; i < 26; i++) begin
            if (s1_mag_q[i]) begin
                w_pos = 5'(i);
            end
        end
    end

    // Leading one lands on bit 25; the two bits below the fraction are the
    // only bits that can ever be discarded, so no separate sticky is needed.
    assign w_norm = s2_mag_q << (c_top_bit - s2_pos_q);

`ifdef FIXED_TO_FLOAT_ROUND_EN
    logic        w_round_up;
    logic [23:0] w_frac_sum;

    assign w_round_up = s3_grd_q[1] & (s3_grd_q[0] | s3_frac_q[0]);
    assign w_frac_sum = {1'b0, s3_frac_q} + {23'd0, w_round_up};
    assign w_frac_rnd = w_frac_sum[22:0];
    assign w_exp_rnd  = s3_exp_q + {7'd0, w_frac_sum[23]};
`else
    assign w_frac_rnd = s3_frac_q;
    assign w_exp_rnd  = s3_exp_q;
`endif

    assign w_packed = s3_zero_q ? 32'h0000_0000 : {s3_sign_q, w_exp_rnd, w_frac_rnd};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_mag_d    = s1_mag_q;
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_mag_d    = s2_mag_q;
        s2_pos_d    = s2_pos_q;
        s3_valid_d  = s3_valid_q;
        s3_sign_d   = s3_sign_q;
        s3_zero_d   = s3_zero_q;
        s3_exp_d    = s3_exp_q;
        s3_frac_d   = s3_frac_q;
`ifdef FIXED_TO_FLOAT_ROUND_EN
        s3_grd_d    = s3_grd_q;
`endif
        out_valid_d = out_valid_q;
        result_d    = result_q;

        if (w_advance) begin
            s1_valid_d  = in_valid;
            s1_sign_d   = fixedpoint_in[25];
            s1_mag_d    = w_mag;

            s2_valid_d  = s1_valid_q;
            s2_sign_d   = s1_sign_q;
            s2_mag_d    = s1_mag_q;
            s2_pos_d    = w_pos;

            s3_valid_d  = s2_valid_q;
            s3_sign_d   = s2_sign_q;
            s3_zero_d   = ~w_norm[25];
            s3_exp_d    = c_exp_bias + {3'd0, s2_pos_q};
            s3_frac_d   = 23'(w_norm >> 2);
`ifdef FIXED_TO_FLOAT_ROUND_EN
            s3_grd_d    = w_norm[1:0];
`endif

            out_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                result_d = w_packed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_mag_q    <= '0;
            s2_pos_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_sign_q   <= 1'b0;
            s3_zero_q   <= 1'b1;
            s3_exp_q    <= '0;
            s3_frac_q   <= '0;
`ifdef FIXED_TO_FLOAT_ROUND_EN
            s3_grd_q    <= '0;
`endif
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_mag_q    <= s2_mag_d;
            s2_pos_q    <= s2_pos_d;
            s3_valid_q  <= s3_valid_d;
            s3_sign_q   <= s3_sign_d;
            s3_zero_q   <= s3_zero_d;
            s3_exp_q    <= s3_exp_d;
            s3_frac_q   <= s3_frac_d;
`ifdef FIXED_TO_FLOAT_ROUND_EN
            s3_grd_q    <= s3_grd_d;
`endif
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_to_float.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_to_float
// Purpose  : Self-checking bench for fixed_to_float (vector table, directed
//            handshake/reset sequences, randomized stream vs. arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float;

`ifdef FIXED_TO_FLOAT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [25:0] fixedpoint_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [25:0] x;
        logic [31:0] y;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    fixed_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .fixedpoint_in(fixedpoint_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result       (result),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    // Reference: value = x / 2^24, converted with plain integer arithmetic.
    function automatic logic [31:0] model(input logic [25:0] x);
        longint v, mag, q, scale;
        int e;
        logic s;
        v = longint'(x);
        if (x[25]) v = v - 64'sd67108864;
        s = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 32'h0;
        e = 0;
        while ((longint'(1) << (e + 1)) <= mag) e++;
        if (e <= 23) begin
            q = mag << (23 - e);
        end else begin
            scale = longint'(1) << (e - 23);
            q = mag / scale;
`ifdef FIXED_TO_FLOAT_ROUND_EN
            begin
                longint rem;
                rem = mag % scale;
                if ((rem * 2 > scale) || ((rem * 2 == scale) && (q % 2 == 1))) q++;
                if (q == (longint'(1) << 24)) begin
                    q = q / 2;
                    e++;
                end
            end
`endif
        end
        return {s, 8'(e + 103), 23'(q - (longint'(1) << 23))};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    // Scoreboard: expected results queued on input handshake, popped on output.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_output: got %08h, expected no output", result);
                end else begin
                    check("scoreboard", result, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(fixedpoint_in));
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [25:0] x);
        fixedpoint_in = x;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got in_ready=0 for 64 cycles, expected acceptance");
        in_valid = 1'b0;
    endtask

    // Single sample with exact 3-cycle latency check.
    task automatic run_single(input string nm, input logic [25:0] x, input logic [31:0] req);
        @(posedge clk); #1;
        fixedpoint_in = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_result"}, result, req);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [25:0] bp[5];
        bit got;
        bit rand_done;

        tbl[0]  = '{26'h0000000, 32'h00000000};
        tbl[1]  = '{26'h2000000, 32'hC0000000};
        tbl[2]  = '{26'h0000001, 32'h33800000};
        tbl[3]  = '{26'h1000000, 32'h3F800000};
        tbl[4]  = '{26'h3000000, 32'hBF800000};
        tbl[5]  = '{26'h0800000, 32'h3F000000};
        tbl[6]  = '{26'h1FFFFFF, ROUND ? 32'h40000000 : 32'h3FFFFFFF};
        tbl[7]  = '{26'h1FFFFFE, 32'h3FFFFFFF};
        tbl[8]  = '{26'h1000001, 32'h3F800000};
        tbl[9]  = '{26'h1000003, ROUND ? 32'h3F800002 : 32'h3F800001};
        tbl[10] = '{26'h2000001, ROUND ? 32'hC0000000 : 32'hBFFFFFFF};
        tbl[11] = '{26'h3FFFFFF, 32'hB3800000};
        tbl[12] = '{26'h0000003, 32'h34400000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Back-to-back basic conversion with cycle-exact output
        fixedpoint_in = 26'h1000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        fixedpoint_in = 26'h3000000;
        @(posedge clk); #1;
        fixedpoint_in = 26'h0800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("basic_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("basic0_valid", 32'(out_valid), 32'd1);
        check("basic0_result", result, 32'h3F800000);
        @(negedge clk);
        check("basic1_valid", 32'(out_valid), 32'd1);
        check("basic1_result", result, 32'hBF800000);
        @(negedge clk);
        check("basic2_valid", 32'(out_valid), 32'd1);
        check("basic2_result", result, 32'h3F000000);
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            run_single($sformatf("vec%0d", i), tbl[i].x, tbl[i].y);
        end
        drain();

        // Back-pressure: hold out_ready low for 4 cycles after first result
        bp[0] = 26'h0400000; bp[1] = 26'h3C00000; bp[2] = 26'h1234567;
        bp[3] = 26'h2ABCDEF; bp[4] = 26'h0000010;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) send(bp[i]);
            end
            begin
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(posedge clk); #1;
                    if (out_valid) got = 1'b1;
                end
                check("bp_first_result", 32'(got), 32'd1);
                out_ready = 1'b0;
                held = result;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    check("bp_valid_held", 32'(out_valid), 32'd1);
                    check("bp_result_stable", result, held);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two samples in flight
        send(26'h0800000);
        send(26'h3000000);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_single("post_reset", 26'h1000000, 32'h3F800000);
        drain();

        // Randomized stream with random back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [25:0] x;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    case ($urandom_range(0, 3))
                        0: x = 26'($urandom_range(0, 255));
                        1: x = 26'h2000000 | 26'($urandom_range(0, 3));
                        2: x = 26'h1FFFFFF - 26'($urandom_range(0, 7));
                        default: x = 26'($urandom);
                    endcase
                    send(x);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
